dst_stream: RTL and testbench

DST_STREAM -- requirements
Module: dst_stream

---
 rtl/dst_pkg.sv | 14 +
 rtl/dst_bank_ram.sv | 34 +++
 rtl/dst_stream.sv | 162 ++++++++++++++++
 tb/tb_dst_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_pkg.sv
// Shared constants and read-side state type for the destination tile streamer.
package dst_pkg;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/dst_bank_ram.sv
// One tile bank: simple dual-port RAM, DEPTH x DW, write port and 1-cycle registered read port.
// The read register holds its value while re is low, and resets to zero (contents do not).
module dst_bank_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dst_stream.sv
// Ping-pong tile buffer: accumulator results written by address, drained as an AXI-stream, one tile per packet.
// Optional DST_STREAM_FRAME_CNT_EN adds a 16-bit count of completed tiles.
module dst_stream
  import dst_pkg::*;
#(
  parameter int DW    = dst_pkg::DW,
  parameter int DEPTH = dst_pkg::DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_period,
  input  logic [AW-1:0] out_addr,
  input  logic          out_fin,
  input  logic [DW-1:0] in_data,
  output logic          dst_full,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          wr_err
`ifdef DST_STREAM_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [AW-1:0] rc;
  logic [AW-1:0] rc_nxt;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;

  logic wr_full;
  logic wr_ok;
  logic fin_ok;
  logic xfer;
  logic last_xfer;

  assign wr_full   = full[wr_bank];
  assign wr_ok     = out_period & ~wr_full;
  assign fin_ok    = out_fin & ~wr_full;
  assign dst_full  = wr_full;

  assign m_tvalid  = (state == ST_STREAM);
  assign m_tlast   = m_tvalid & (rc == LAST);
  assign xfer      = m_tvalid & m_tready;
  assign last_xfer = xfer & (rc == LAST);

  // The RAM read register doubles as the output stage: it is only re-enabled
  // on a transfer, so data holds across stalls and the next word is already
  // fetched when the current one leaves.
  assign m_tdata = rd_bank ? q1 : q0;

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    rd_en     = 1'b0;
    rd_addr   = rc;
    case (state)
      ST_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = ST_LOAD;
          rc_nxt    = '0;
        end
      end
      ST_LOAD: begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer) begin
          if (rc == LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            rc_nxt  = rc + AW'(1);
            rd_en   = 1'b1;
            rd_addr = rc + AW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
    end
  end

  // Set and clear always target different banks: a bank being drained is
  // full, and a tile can only complete into a bank that is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      wr_err  <= 1'b0;
    end else begin
      if (fin_ok) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (last_xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if ((out_period | out_fin) & wr_full) begin
        wr_err <= 1'b1;
      end
    end
  end

`ifdef DST_STREAM_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (last_xfer) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  dst_bank_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~wr_bank),
    .waddr (out_addr),
    .wdata (in_data),
    .re    (rd_en & ~rd_bank),
    .raddr (rd_addr),
    .rdata (q0)
  );

  dst_bank_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & wr_bank),
    .waddr (out_addr),
    .wdata (in_data),
    .re    (rd_en & rd_bank),
    .raddr (rd_addr),
    .rdata (q1)
  );

endmodule

// File: tb/tb_dst_stream.sv
// Directed self-checking bench for dst_stream: single tile, stalls, double buffering, overflow, mid-stream reset.
module tb_dst_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_period;
  logic [AW-1:0] out_addr;
  logic          out_fin;
  logic [DW-1:0] in_data;
  logic          dst_full;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          wr_err;
`ifdef DST_STREAM_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dst_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_period (out_period),
    .out_addr   (out_addr),
    .out_fin    (out_fin),
    .in_data    (in_data),
    .dst_full   (dst_full),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .wr_err     (wr_err)
`ifdef DST_STREAM_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tile(input logic [DW-1:0] base);
    for (int a = 0; a < DEPTH; a++) begin
      out_period = 1'b1;
      out_addr   = AW'(a);
      in_data    = base + DW'(a);
      tick();
    end
    out_period = 1'b0;
    out_fin    = 1'b1;
    tick();
    out_fin    = 1'b0;
  endtask

  // Drains up to stop_at beats, checking value, tlast, stall hold and (optionally) dst_full.
  task automatic stream_tile(input logic [DW-1:0] base, input bit toggle, input bit chk_full,
                             input int stop_at, input string name);
    int beat = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp;
    while (beat < stop_at && cyc < 400) begin
      m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        n_tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== held) begin
          n_fail++;
          $display("FAIL %s stall_hold beat %0d: valid=%b data=%h, required valid=1 data=%h",
                   name, beat, m_tvalid, m_tdata, held);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        exp = base + DW'(beat);
        n_tests++;
        if (m_tdata !== exp) begin
          n_fail++;
          $display("FAIL %s data beat %0d: got %h, required %h", name, beat, m_tdata, exp);
        end
        n_tests++;
        if (m_tlast !== ((beat == DEPTH - 1) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL %s tlast beat %0d: got %b, required %b", name, beat, m_tlast, beat == DEPTH - 1);
        end
        if (chk_full) begin
          n_tests++;
          if (dst_full !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dst_full beat %0d: got %b, required 1", name, beat, dst_full);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        beat++;
        stalled = 1'b0;
      end else if (m_tvalid === 1'b1) begin
        stalled = 1'b1;
        held = m_tdata;
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (beat != stop_at) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats, required %0d", name, beat, stop_at);
    end
    if (!toggle && stop_at == DEPTH) begin
      n_tests++;
      if (last - first != DEPTH - 1) begin
        n_fail++;
        $display("FAIL %s throughput: span %0d cycles, required %0d", name, last - first, DEPTH - 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || dst_full !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: valid=%b last=%b data=%h full=%b err=%b, required all zero",
               name, m_tvalid, m_tlast, m_tdata, dst_full, wr_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_period = 1'b0; out_fin = 1'b0; out_addr = '0; in_data = '0; m_tready = 1'b0;
    tick(); tick();
    check_idle_outputs("reset_state");
`ifdef DST_STREAM_FRAME_CNT_EN
    n_tests++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_tile();
    write_tile(32'h100);
    n_tests++;
    if (dst_full !== 1'b0) begin
      n_fail++;
      $display("FAIL single_dst_full: got %b, required 0", dst_full);
    end
    stream_tile(32'h100, 1'b0, 1'b0, DEPTH, "single");
    n_tests++;
    if (m_tvalid !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: valid=%b err=%b, required 0 0", m_tvalid, wr_err);
    end
  endtask

  task automatic test_stall();
    write_tile(32'h100);
    stream_tile(32'h100, 1'b1, 1'b0, DEPTH, "stall");
    n_tests++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end_valid: got %b, required 0", m_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b0;
    write_tile(32'h200);
    n_tests++;
    if (dst_full !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_after_a: got %b, required 0", dst_full);
    end
    write_tile(32'h300);
    n_tests++;
    if (dst_full !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full_after_b: got %b, required 1", dst_full);
    end
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_err_before_c: got %b, required 0", wr_err);
    end
    write_tile(32'h400);
    n_tests++;
    if (wr_err !== 1'b1 || dst_full !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overflow: err=%b full=%b, required 1 1", wr_err, dst_full);
    end
    stream_tile(32'h200, 1'b0, 1'b1, DEPTH, "b2b_tile_a");
    n_tests++;
    if (dst_full !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after_a: full=%b valid=%b, required 0 0", dst_full, m_tvalid);
    end
    stream_tile(32'h300, 1'b0, 1'b0, DEPTH, "b2b_tile_b");
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_no_third cycle %0d: valid=%b, required 0", i, m_tvalid);
      end
      tick();
    end
    n_tests++;
    if (wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_err_sticky: got %b, required 1", wr_err);
    end
  endtask

  task automatic test_reset_mid();
    write_tile(32'h500);
    stream_tile(32'h500, 1'b0, 1'b0, 20, "mid_prefix");
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_reset_state");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_beats cycle %0d: valid=%b, required 0", i, m_tvalid);
      end
    end
    write_tile(32'h600);
    stream_tile(32'h600, 1'b0, 1'b0, DEPTH, "mid_fresh");
  endtask

`ifdef DST_STREAM_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int t = 1; t <= 3; t++) begin
      write_tile(32'h1000 * t);
      stream_tile(32'h1000 * t, 1'b0, 1'b0, DEPTH, "frame");
      n_tests++;
      if (frame_cnt !== 16'(t)) begin
        n_fail++;
        $display("FAIL frame_cnt tile %0d: got %0d, required %0d", t, frame_cnt, t);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_tile();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef DST_STREAM_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
